// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: bus-attached 8N1 UART receiver feeding a small receive FIFO.
// The serial input passes through a two-flop synchronizer. A five-state FSM
// samples every bit at mid-bit and hands each completed byte to the FIFO one
// cycle later. The CPU reads DATA (pop) and STATUS through the cs / bus_addr
// / bus_bytesel peripheral bus.
// Optional feature macro: UART_BREAK_IRQ_EN. When it is defined, a received
// 0x03 raises a break interrupt instead of entering the FIFO.
// "int" is a reserved word in SystemVerilog, so the interrupt request output
// is named intr.
`timescale 1ns/1ps

module uart_rx_fifo #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        cs,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic [3:0]  bus_bytesel,
  output logic        bus_ack,
  output logic [31:0] bus_data,
  output logic        intr,
  input  logic        intack
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAITHI
  } state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [2:0]        bit_q, bit_n;
  logic [7:0]        sh_q, sh_n;
  logic              rx_m, rx_s;
  logic              expired;
  logic              stop_ok;
  logic              ferr_set;

  logic              vld_p1;
  logic [7:0]        byte_p1;

  logic [7:0]        mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr, rd_ptr;
  logic              full, empty;
  logic              rd_req, wr_req;
  logic              pop, push, push_req, ovr_set;
  logic              is_brk;
  logic              brk_flag;
  logic              ovr_q, ferr_q;
  logic              clr_ovr, clr_ferr;
  logic [31:0]       rd_val;

  // Two-flop synchronizer on the asynchronous serial input (idles high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign expired = (cnt_q == '0);

  // Receive FSM next-state logic: bit timing, glitch reject, framing check.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    bit_n    = bit_q;
    sh_n     = sh_q;
    stop_ok  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = HALF_LD;
        end
      end
      S_START: begin
        if (expired) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            cnt_n   = FULL_LD;
            bit_n   = 3'd0;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (expired) begin
          sh_n  = {rx_s, sh_q[7:1]};
          cnt_n = FULL_LD;
          bit_n = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = S_STOP;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (expired) begin
          if (rx_s) begin
            stop_ok = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = S_WAITHI;
          end
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end
      S_WAITHI: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Receive FSM control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
    end
  end

  // Shift register and push-stage byte: pure data, no reset needed.
  always_ff @(posedge clk) begin
    sh_q    <= sh_n;
    byte_p1 <= sh_q;
  end

  // ---- p1: completed byte is presented to the FIFO one cycle after stop ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= stop_ok;
  end

  assign rd_req = cs & (bus_bytesel != 4'b0001);
  assign wr_req = cs & (bus_bytesel == 4'b0001);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // Only the first cycle of a cs burst pops, so a long strobe consumes one byte.
  assign pop = rd_req & ~bus_ack & (bus_addr[2:0] == 3'b000) & ~empty;

`ifdef UART_BREAK_IRQ_EN
  assign is_brk = vld_p1 & (byte_p1 == 8'h03);
`else
  assign is_brk = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_req = vld_p1 & ~is_brk;
  assign push     = push_req & (~full | pop);
  assign ovr_set  = push_req & full & ~pop;

  assign clr_ovr  = wr_req & (bus_addr[2:0] == 3'b100) & bus_wr_val[0];
  assign clr_ferr = wr_req & (bus_addr[2:0] == 3'b100) & bus_wr_val[2];

  // FIFO storage; reads of the old head happen before this write lands.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= byte_p1;
  end

  // FIFO pointers; one extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags: a new event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~clr_ovr);
      ferr_q <= ferr_set | (ferr_q & ~clr_ferr);
    end
  end

`ifdef UART_BREAK_IRQ_EN
  // Break pending: set by a received 0x03; a same-cycle 0x03 beats intack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) brk_flag <= 1'b0;
    else     brk_flag <= is_brk | (brk_flag & ~intack);
  end
  assign intr = brk_flag;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[31:3], bus_wr_val[31:3], bus_wr_val[1]};
`else
  assign brk_flag = 1'b0;
  assign intr     = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[31:3], bus_wr_val[31:3], bus_wr_val[1],
                         intack, byte_p1 == 8'h03};
`endif

  // Read mux: register selected by address bits [2:0].
  always_comb begin
    rd_val = 32'd0;
    case (bus_addr[2:0])
      3'b000:  if (!empty) rd_val = {24'd0, mem[rd_ptr[FIFO_AW-1:0]]};
      3'b100:  rd_val = {28'd0, brk_flag, ferr_q, ~empty, ovr_q};
      default: rd_val = 32'd0;
    endcase
  end

  // Bus response: ack is cs delayed one cycle; data only on reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ack  <= 1'b0;
      bus_data <= 32'd0;
    end else begin
      bus_ack  <= cs;
      bus_data <= rd_req ? rd_val : 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLK_DIV=16, 8-entry FIFO).
// The reference model is a byte queue plus sticky flags, updated per frame.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        cs = 1'b0;
  logic        intack = 1'b0;
  logic [31:0] bus_addr = 32'd0;
  logic [31:0] bus_wr_val = 32'd0;
  logic [3:0]  bus_bytesel = 4'hF;
  logic        bus_ack;
  logic [31:0] bus_data;
  logic        intr;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .cs(cs), .bus_addr(bus_addr),
    .bus_wr_val(bus_wr_val), .bus_bytesel(bus_bytesel), .bus_ack(bus_ack),
    .bus_data(bus_data), .intr(intr), .intack(intack)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] q[$];
  logic       ovr_m = 1'b0;
  logic       ferr_m = 1'b0;
  logic       brk_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: what the receiver should do with one well-framed byte.
  task automatic model_rx(input logic [7:0] b);
`ifdef UART_BREAK_IRQ_EN
    if (b == 8'h03) begin
      brk_m = 1'b1;
      return;
    end
`endif
    if (q.size() < DEPTH) q.push_back(b);
    else ovr_m = 1'b1;
  endtask

  function automatic logic [31:0] status_exp();
    return {28'd0, brk_m, ferr_m, (q.size() != 0), ovr_m};
  endfunction

  task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_lvl);
    @(negedge clk);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (stop_cycles) @(negedge clk);
    rx = 1'b1;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, CLK_DIV, 1'b1);
    model_rx(b);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1;
    bus_addr = $urandom();
    bus_addr[2:0] = a;
    bus_bytesel = 4'b1111;
    @(negedge clk);
    check("read_ack", {31'd0, bus_ack}, 32'd1);
    d = bus_data;
    cs = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    cs = 1'b1;
    bus_addr = 32'd0;
    bus_addr[2:0] = a;
    bus_wr_val = v;
    bus_bytesel = 4'b0001;
    @(negedge clk);
    check("write_data_zero", bus_data, 32'd0);
    cs = 1'b0;
    bus_bytesel = 4'b1111;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(3'b100, d);
    check(tag, d, status_exp());
  endtask

  task automatic check_data(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = 32'd0;
    if (q.size() != 0) exp = {24'd0, q.pop_front()};
    bus_read(3'b000, d);
    check(tag, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] d;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_ack", {31'd0, bus_ack}, 32'd0);
    check("rst_data", bus_data, 32'd0);
    check("rst_int", {31'd0, intr}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_status("status_after_reset");

    // Single frame 0x41
    send_good(8'h41);
    check_status("status_rdy_0x41");
    check_data("data_0x41");
    check_status("status_empty_0x41");

    // Overflow: nine bytes into eight slots
    for (int i = 0; i < 9; i++) send_good(8'h10 + 8'(i));
    check_status("status_ovr");
    for (int i = 0; i < 8; i++) check_data("data_ovr_drain");
    check_status("status_ovr_empty");
    bus_write(3'b100, 32'h1);
    ovr_m = 1'b0;
    check_status("status_ovr_cleared");

    // Short glitch is rejected
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check_status("status_glitch");
    send_good(8'h55);
    check_data("data_0x55");

    // Framing error: stop bit held low
    send_frame(8'hA5, 40, 1'b0);
    ferr_m = 1'b1;
    check_status("status_ferr");
    send_good(8'h5A);
    bus_write(3'b000, 32'hFFFF_FFFF);
    check_status("status_ferr_rdy");
    check_data("data_0x5a");
    bus_write(3'b100, 32'h4);
    ferr_m = 1'b0;
    check_status("status_ferr_cleared");

    // Ctrl-C handling
    send_good(8'h03);
`ifdef UART_BREAK_IRQ_EN
    check("brk_int_set", {31'd0, intr}, 32'd1);
    check_status("status_brk");
    @(negedge clk);
    intack = 1'b1;
    @(negedge clk);
    intack = 1'b0;
    brk_m = 1'b0;
    check("brk_int_clear", {31'd0, intr}, 32'd0);
    check_status("status_brk_clear");
`else
    check("brk_int_low", {31'd0, intr}, 32'd0);
    check_data("data_0x03");
`endif

    // Multi-cycle cs on DATA pops once
    send_good(8'hC3);
    send_good(8'h3C);
    @(negedge clk);
    cs = 1'b1;
    bus_addr = 32'd0;
    bus_bytesel = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("burst_ack", {31'd0, bus_ack}, 32'd1);
      if (i == 0) check("burst_data", bus_data, {24'd0, q.pop_front()});
    end
    cs = 1'b0;
    @(negedge clk);
    check("burst_ack_low", {31'd0, bus_ack}, 32'd0);
    check("burst_data_idle", bus_data, 32'd0);
    check_data("data_after_burst");
    check_status("status_after_burst");

    // Randomized frames with random reads
    for (int n = 0; n < 14; n++) begin
      b = 8'($urandom_range(0, 255));
      send_good(b);
`ifdef UART_BREAK_IRQ_EN
      check("rand_int", {31'd0, intr}, {31'd0, brk_m});
`else
      check("rand_int", {31'd0, intr}, 32'd0);
`endif
      if ($urandom_range(0, 2) != 0) check_data("rand_data");
      if ($urandom_range(0, 3) == 0) check_status("rand_status");
    end
    check_status("rand_status_final");
    while (q.size() != 0) check_data("rand_drain");
    check_data("rand_empty_read");
    bus_write(3'b100, 32'h5);
    ovr_m = 1'b0;
    ferr_m = 1'b0;
`ifdef UART_BREAK_IRQ_EN
    @(negedge clk);
    intack = 1'b1;
    @(negedge clk);
    intack = 1'b0;
    brk_m = 1'b0;
`endif
    check_status("status_before_rst_test");

    // Reset mid-frame with a byte queued and a read in flight
    send_good(8'h99);
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CLK_DIV) @(negedge clk);
    cs = 1'b1;
    bus_addr = 32'h4;
    bus_bytesel = 4'b1111;
    @(negedge clk);
    check("pre_rst_ack", {31'd0, bus_ack}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'd0, bus_ack}, 32'd0);
    check("midrst_data", bus_data, 32'd0);
    check("midrst_int", {31'd0, intr}, 32'd0);
    cs = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete();
    ovr_m = 1'b0;
    ferr_m = 1'b0;
    brk_m = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);
    check_status("status_after_midrst");
    check_data("data_after_midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
